// File: rtl/sum_accumulator_pkg.sv
// Purpose: shared state encoding and width helpers for the sum_accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_accumulator_pkg;

  // Encodings are fixed so that waveforms and any external debug taps stay stable.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_HOLD  = ST_HOLD
  } state_e;

  // A frame of up to 2^count_w samples of n-bit values needs n+count_w bits to hold the total.
  function automatic int acc_width(input int n, input int count_w);
    return n + count_w;
  endfunction

  // True when a frame whose sample count has just become new_cnt is complete.
  // len is the programmed "samples minus one" value.
  function automatic logic frame_full(input int new_cnt, input int len);
    return (new_cnt == len + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator_frame_counter.sv
// Purpose: per-frame sample counter, frame-length latch and last-sample detect.
// Latency: cnt updates one cycle after start/step; done is combinational for the current accept.
// Backpressure: none of its own; the parent only pulses start/step on an accepted sample.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear           drop the partial frame (count back to zero)
//   start           first accepted sample of a frame; latches frame_len
//   step            further accepted sample within a frame
//   frame_len       samples per frame minus one (only looked at with start)
//   cnt             samples accepted so far in the current/held frame
//   done            this accept completes the frame
module sum_accumulator_frame_counter
  import sum_accumulator_pkg::*;
#(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               start,
  input  logic               step,
  input  logic [COUNT_W-1:0] frame_len,
  output logic [COUNT_W:0]   cnt,
  output logic               done
);

  localparam logic [COUNT_W:0] CNT_ONE = {{COUNT_W{1'b0}}, 1'b1};

  logic [COUNT_W:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] len_q, len_d;

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    done  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      // frame_len is captured here and never looked at again until the next frame,
      // so mid-frame changes on the input are harmless.
      cnt_d = CNT_ONE;
      len_d = frame_len;
      done  = frame_full(1, int'(frame_len));
    end else if (step) begin
      cnt_d = cnt_q + CNT_ONE;
      done  = frame_full(int'(cnt_q) + 1, int'(len_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sum_accumulator.sv
// Purpose: accumulate a programmable-length frame of adder results into one total + sample count.
// Latency: out_valid rises the cycle after the frame's last accepted sample.
// Backpressure: in_ready drops while a finished frame waits for out_ready; one sample/cycle otherwise.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        sample handshake, in_data is the unsigned adder result
//   frame_len                samples per frame minus one, taken with the first sample of a frame
//   abort                    discard a partial frame (ignored once the frame is complete)
//   out_valid/out_ready      result handshake
//   out_sum                  frame total, zero-extended arithmetic, cannot overflow
//   out_count                samples in the frame (1..2^COUNT_W)
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int N       = 4,
  parameter int COUNT_W = 4,
  parameter int ACC_W   = acc_width(N, COUNT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic [COUNT_W-1:0] frame_len,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W:0]   out_count
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   in_ext;
  logic [COUNT_W:0]   cnt;
  logic               accept;
  logic               rel;
  logic               fc_clear;
  logic               fc_start;
  logic               fc_step;
  logic               fc_done;

  assign in_ext = {{(ACC_W-N){1'b0}}, in_data};

  // Outputs decode registered state only. rst masks them so the block looks idle
  // in every cycle reset is held, including the very first one before any edge.
  assign in_ready  = ~rst & (state_q != S_HOLD);
  assign out_valid = ~rst & (state_q == S_HOLD);
  assign out_sum   = rst ? '0 : acc_q;
  assign out_count = rst ? '0 : cnt;

  assign accept = in_valid & in_ready;
  assign rel    = out_valid & out_ready;

  sum_accumulator_frame_counter #(
    .COUNT_W (COUNT_W)
  ) u_frame_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (fc_clear),
    .start     (fc_start),
    .step      (fc_step),
    .frame_len (frame_len),
    .cnt       (cnt),
    .done      (fc_done)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    fc_clear = 1'b0;
    fc_start = 1'b0;
    fc_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort outranks a same-cycle accept: that sample is dropped.
        if (abort) begin
          fc_clear = 1'b1;
          acc_d    = '0;
        end else if (accept) begin
          fc_start = 1'b1;
          acc_d    = in_ext;
          state_d  = fc_done ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          fc_clear = 1'b1;
          acc_d    = '0;
          state_d  = S_IDLE;
        end else if (accept) begin
          fc_step = 1'b1;
          acc_d   = acc_q + in_ext;
          if (fc_done) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // The result is complete; abort and in_valid have no effect here.
        // Release goes to IDLE, so no sample is taken in the release cycle.
        if (rel) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Purpose: randomized + directed scoreboard bench for sum_accumulator.
// Latency: expects out_valid the cycle after the last accepted sample of a frame.
// Backpressure: exercises out_ready low with in_valid held high.
module tb_sum_accumulator;

  localparam int N       = 4;
  localparam int COUNT_W = 4;
  localparam int ACC_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic [COUNT_W-1:0] frame_len;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [COUNT_W:0]   out_count;

  sum_accumulator #(
    .N       (N),
    .COUNT_W (COUNT_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .frame_len (frame_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry: expected total, expected count, cycle at which out_valid must first appear.
  typedef struct {
    int sum;
    int cnt;
    int when;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a frame is just a list of samples; it closes when it holds len+1 entries.
  bit pending = 0;
  bit active  = 0;
  int len     = 0;
  int samples[$];
  bit mon_en  = 0;
  bit holding = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_eval();
    bit rel;
    int s;
    check("in_ready", {31'd0, in_ready}, {31'd0, !pending});
    check("out_valid", {31'd0, out_valid}, {31'd0, pending});
    rel = pending && out_ready;
    if (!pending) begin
      if (abort) begin
        active = 0;
        samples.delete();
      end else if (in_valid) begin
        if (!active) begin
          active = 1;
          len    = int'(frame_len);
          samples.delete();
        end
        samples.push_back(int'(in_data));
        if (samples.size() == len + 1) begin
          s = 0;
          foreach (samples[i]) s += samples[i];
          exp_q.push_back('{s, samples.size(), cyc + 1});
          active  = 0;
          pending = 1;
        end
      end
    end else if (rel) begin
      pending = 0;
    end
  endtask

  task automatic step(input bit v, input int d, input int fl, input bit ab, input bit ordy);
    in_valid  = v;
    in_data   = d[N-1:0];
    frame_len = fl[COUNT_W-1:0];
    abort     = ab;
    out_ready = ordy;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum=%0d count=%0d with nothing expected (cycle %0d)",
                 out_sum, out_count, cyc);
      end else begin
        check("out_sum", {24'd0, out_sum}, exp_q[0].sum);
        check("out_count", {27'd0, out_count}, exp_q[0].cnt);
        if (!holding) check("result_latency", cyc, exp_q[0].when);
        holding = 1;
        if (out_ready) begin
          void'(exp_q.pop_front());
          holding = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd5;
    frame_len = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    // Reset held for two edges with in_valid high.
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {24'd0, out_sum}, 32'd0);
    check("rst_out_count", {27'd0, out_count}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_out_count", {27'd0, out_count}, 32'd0);
    mon_en = 1;
    @(posedge clk);
    #1;

    // Four-sample frame 5,7,2,9 -> 23.
    step(1, 5, 3, 0, 1);
    step(1, 7, 3, 0, 1);
    step(1, 2, 3, 0, 1);
    step(1, 9, 3, 0, 1);
    step(0, 0, 3, 0, 1);
    step(0, 0, 3, 0, 1);

    // Maximum frame: 16 x 15 -> 240, count 16.
    for (int i = 0; i < 16; i++) step(1, 15, 15, 0, 1);
    step(0, 0, 15, 0, 1);
    step(0, 0, 15, 0, 1);

    // Single-sample frame.
    step(1, 6, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Backpressure with a pending sample held on the input.
    step(1, 3, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 9, 0, 0, 0);
    step(1, 9, 0, 0, 1);
    step(1, 9, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Abort mid-frame drops the concurrent sample; then a frame whose frame_len changes mid-way.
    step(1, 4, 3, 0, 1);
    step(1, 4, 3, 0, 1);
    step(1, 8, 3, 1, 1);
    step(0, 0, 3, 0, 1);
    step(1, 1, 1, 0, 1);
    step(1, 1, 7, 0, 1);
    step(0, 0, 7, 0, 1);
    step(0, 0, 7, 0, 1);

    // Abort while holding a finished result has no effect.
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int fl;
      fl = (($urandom % 8) == 0) ? 15 : int'($urandom_range(0, 4));
      step(($urandom % 4) != 0, int'($urandom_range(0, 15)), fl,
           ($urandom % 30) == 0, ($urandom % 3) != 0);
    end

    // Drain: stop input and let any finished frame be released.
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pending || exp_q.size() != 0) step(0, 0, 0, 0, 1);
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
